// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, mid-bit sampling, one-cycle valid/frame-error pulses.
// Ports:
//   clk       - single clock, rising edge
//   rst_n     - asynchronous active-low reset
//   rx        - serial line, asynchronous to clk, idle high
//   rx_data   - last correctly framed byte (held between rx_valid pulses)
//   rx_valid  - one-cycle pulse, rx_data updated in the same cycle
//   frame_err - one-cycle pulse when the stop bit is sampled low
//   rx_busy   - high whenever the receiver is not idle
// Build option: define UART_RX_MAJORITY_EN to take each bit as the majority of
// three consecutive synchronized samples ending at the sample point.
module uart_rx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_END = 16'(HALF_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        sync_q, rx_s_q;
    logic        samp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            sync_q <= rx;
            rx_s_q <= sync_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // hist_q holds rx_s from the two previous cycles; the counter advances every
    // cycle inside a bit, so these line up with counter values S-1 and S-2.
    logic [1:0] hist_q, hist_d;
    assign hist_d = {hist_q[0], rx_s_q};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist_q <= 2'b11;
        else        hist_q <= hist_d;
    end
    assign samp = (rx_s_q & hist_q[0]) | (rx_s_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign samp = rx_s_q;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = 16'd0;
                end
            end
            START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d   = 16'd0;
                    idx_d   = 3'd0;
                    state_d = samp ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_END) begin
                    shift_d[idx_q] = samp;
                    cnt_d          = 16'd0;
                    idx_d          = idx_q + 3'd1;
                    state_d        = (idx_q == 3'd7) ? STOP : DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d       = 16'd0;
                    rx_data_d   = samp ? shift_q : rx_data_q;
                    rx_valid_d  = samp;
                    frame_err_d = !samp;
                    state_d     = samp ? IDLE : WAIT_HIGH;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WAIT_HIGH: begin
                // A held-low line (break) reports once, then waits for idle.
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = (state_q != IDLE);
endmodule
